inst_fetch_unit: RTL

//   Upstream fetch stage for the multi-cycle processor. Holds the instruction

---
 rtl/inst_fetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Upstream fetch stage for the multi-cycle processor. Holds the instruction
//   memory and the fetch PC, and prefetches instructions into a small FIFO
//   that is presented to decode over a valid/ready handshake. The execute
//   stage redirects fetch (branches/jumps) through redirect_valid/redirect_pc.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst_n          asynchronous, active-low reset
//   prog_we        instruction memory write enable
//   prog_addr      instruction memory write address
//   prog_data      instruction word to write
//   redirect_valid flush FIFO and restart fetch at redirect_pc
//   redirect_pc    new fetch address
//   inst_ready     decode accepts the head instruction this cycle
//   inst_valid     FIFO head is valid
//   inst_data      FIFO head instruction word
//   inst_pc        address the head instruction was fetched from
//   done           fetch finished, FIFO empty, no redirect pending
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int IMEM_DEPTH = 16,
    parameter int PC_W       = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_PC     = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [31:0]     prog_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            inst_ready,
    output logic            inst_valid,
    output logic [31:0]     inst_data,
    output logic [PC_W-1:0] inst_pc,
    output logic            done
);

    localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PC_W-1:0] MAX_PC_V = PC_W'(MAX_PC);
    localparam logic [PC_W-1:0] DEPTH_V  = PC_W'(IMEM_DEPTH);
    localparam logic [CW-1:0]   FULL_V   = CW'(FIFO_DEPTH);

    logic [31:0]     mem       [IMEM_DEPTH];
    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [PC_W-1:0] fifo_pc   [FIFO_DEPTH];

    logic [PC_W-1:0] fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            pop;
    logic            push;
    logic [31:0]     fetch_word;
    logic [PC_W-1:0] fetch_pc_n;
    logic [PW-1:0]   rd_ptr_n;
    logic [PW-1:0]   wr_ptr_n;
    logic [CW-1:0]   count_n;
    logic [31:0]     head_data_n;
    logic [PC_W-1:0] head_pc_n;
    logic            done_n;

    // Next-state logic. The outputs are registered copies of the FIFO head,
    // so the head for the next cycle is computed here. When the FIFO is (or
    // becomes) empty apart from the entry being pushed this edge, that entry
    // has not been written into storage yet, so it is bypassed straight from
    // the memory read. When the FIFO ends up empty, the head values hold.
    always_comb begin
        pop         = inst_valid && inst_ready;
        push        = (fetch_pc < MAX_PC_V) && !redirect_valid &&
                      ((count < FULL_V) || pop);
        fetch_word  = mem[fetch_pc[AW-1:0]];
        fetch_pc_n  = fetch_pc;
        rd_ptr_n    = rd_ptr;
        wr_ptr_n    = wr_ptr;
        count_n     = count;
        head_data_n = inst_data;
        head_pc_n   = inst_pc;

        if (redirect_valid) begin
            fetch_pc_n = redirect_pc;
            rd_ptr_n   = '0;
            wr_ptr_n   = '0;
            count_n    = '0;
        end else begin
            fetch_pc_n = fetch_pc + PC_W'(push);
            rd_ptr_n   = rd_ptr + PW'(pop);
            wr_ptr_n   = wr_ptr + PW'(push);
            count_n    = count + CW'(push) - CW'(pop);
        end

        if (count_n != '0) begin
            if ((count - CW'(pop)) == '0) begin
                head_data_n = fetch_word;
                head_pc_n   = fetch_pc;
            end else begin
                head_data_n = fifo_data[rd_ptr_n];
                head_pc_n   = fifo_pc[rd_ptr_n];
            end
        end

        done_n = (fetch_pc_n >= MAX_PC_V) && (count_n == '0);
    end

    // Control state and registered outputs. Reset discards everything in
    // flight and restarts fetch at PC 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
            done       <= 1'b0;
        end else begin
            fetch_pc   <= fetch_pc_n;
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            count      <= count_n;
            inst_valid <= (count_n != '0);
            inst_data  <= head_data_n;
            inst_pc    <= head_pc_n;
            done       <= done_n;
        end
    end

    // Storage without reset: instruction memory survives reset, and stale
    // FIFO slots are never visible because count gates them. A fetch of an
    // address written this same edge sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we && (prog_addr < DEPTH_V)) begin
            mem[prog_addr[AW-1:0]] <= prog_data;
        end
        if (push) begin
            fifo_data[wr_ptr] <= fetch_word;
            fifo_pc[wr_ptr]   <= fetch_pc;
        end
    end

endmodule
